// File: rtl/rangefinder_sample_capture_ctrl_if.sv
// Port bundle for the rangefinder capture sequencer: control and ADC stream in, RAM port-1 and status out.
// The slave modport is the sequencer side; the master modport is the CPU/ADC/RAM environment side.
interface rangefinder_sample_capture_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              arm;
  logic              abort;
  logic [ADDR_W-1:0] post_count;
  logic              irq_ack;
  logic              sample_valid;
  logic [DATA_W-1:0] sample_data;
  logic              trig_in;

  logic [ADDR_W-1:0] ram_address;
  logic              ram_chipselect;
  logic              ram_write;
  logic [DATA_W-1:0] ram_writedata;

  logic              busy;
  logic              done;
  logic              irq;
  logic [ADDR_W-1:0] trig_addr;
  logic [ADDR_W-1:0] start_addr;

  modport slave (
    input  arm, abort, post_count, irq_ack, sample_valid, sample_data, trig_in,
    output ram_address, ram_chipselect, ram_write, ram_writedata,
    output busy, done, irq, trig_addr, start_addr
  );

  modport master (
    output arm, abort, post_count, irq_ack, sample_valid, sample_data, trig_in,
    input  ram_address, ram_chipselect, ram_write, ram_writedata,
    input  busy, done, irq, trig_addr, start_addr
  );
endinterface

// File: rtl/rangefinder_sample_capture_ctrl.sv
// Write-side sequencer for the sample RAM: circular pre-trigger buffer, trigger capture,
// programmable post-trigger tail, then freeze with done/irq until re-armed.
module rangefinder_sample_capture_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic clk,
  input  logic reset_n,
  rangefinder_sample_capture_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_WAIT,
    S_POST,
    S_DONE
  } state_e;

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  state_e            state_q;
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W-1:0] pcnt_q;
  logic [ADDR_W-1:0] qcnt_q;
  logic [ADDR_W-1:0] post_q;
  logic [ADDR_W-1:0] trig_addr_q;
  logic [ADDR_W-1:0] start_addr_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_data_q;
  logic              ram_we_q;
  logic              busy_q;
  logic              done_q;
  logic              irq_q;

  logic              capturing;
  logic              accept;
  logic [ADDR_W-1:0] pre_len_arm;
  logic [ADDR_W-1:0] pre_len_q;
  logic [ADDR_W-1:0] pcnt_d;
  logic [ADDR_W-1:0] qcnt_d;
  logic [ADDR_W-1:0] start_addr_d;

  // abort suppresses acceptance so nothing new is queued for the RAM once aborted.
  assign capturing    = (state_q == S_FILL) || (state_q == S_WAIT) || (state_q == S_POST);
  assign accept       = capturing && bus.sample_valid && !bus.abort;
  assign pre_len_arm  = ADDR_MAX - bus.post_count;
  assign pre_len_q    = ADDR_MAX - post_q;
  assign pcnt_d       = pcnt_q + 1'b1;
  assign qcnt_d       = qcnt_q + 1'b1;
  assign start_addr_d = wr_ptr_q + post_q + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      pcnt_q       <= '0;
      qcnt_q       <= '0;
      post_q       <= '0;
      trig_addr_q  <= '0;
      start_addr_q <= '0;
      ram_addr_q   <= '0;
      ram_data_q   <= '0;
      ram_we_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      ram_we_q <= accept;
      if (accept) begin
        ram_addr_q <= wr_ptr_q;
        ram_data_q <= bus.sample_data;
        wr_ptr_q   <= wr_ptr_q + 1'b1;
      end

      // Later assignments below (DONE entry) take precedence over the acknowledge.
      if (bus.irq_ack) begin
        irq_q <= 1'b0;
      end

      if (bus.abort) begin
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
        done_q  <= 1'b0;
        irq_q   <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE, S_DONE: begin
            if (bus.arm) begin
              wr_ptr_q <= '0;
              pcnt_q   <= '0;
              post_q   <= bus.post_count;
              irq_q    <= 1'b0;
              done_q   <= 1'b0;
              busy_q   <= 1'b1;
              state_q  <= (pre_len_arm == '0) ? S_WAIT : S_FILL;
            end
          end

          S_FILL: begin
            if (accept) begin
              pcnt_q <= pcnt_d;
              if (pcnt_d == pre_len_q) begin
                state_q <= S_WAIT;
              end
            end
          end

          S_WAIT: begin
            if (accept && bus.trig_in) begin
              trig_addr_q  <= wr_ptr_q;
              start_addr_q <= start_addr_d;
              qcnt_q       <= '0;
              if (post_q == '0) begin
                state_q <= S_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                irq_q   <= 1'b1;
              end else begin
                state_q <= S_POST;
              end
            end
          end

          S_POST: begin
            if (accept) begin
              qcnt_q <= qcnt_d;
              if (qcnt_d == post_q) begin
                state_q <= S_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                irq_q   <= 1'b1;
              end
            end
          end

          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.ram_address    = ram_addr_q;
  assign bus.ram_chipselect = ram_we_q;
  assign bus.ram_write      = ram_we_q;
  assign bus.ram_writedata  = ram_data_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.irq            = irq_q;
  assign bus.trig_addr      = trig_addr_q;
  assign bus.start_addr     = start_addr_q;

endmodule

// File: tb/tb_rangefinder_sample_capture_ctrl.sv
// Directed bench for the capture sequencer: hand-computed trigger/start addresses, write counts,
// irq priority and asynchronous reset, with a RAM shadow built from the observed port-1 writes.
module tb_rangefinder_sample_capture_ctrl;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;
  int   wr_cnt;
  int   base;
  logic [7:0] mem [256];

  rangefinder_sample_capture_ctrl_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  rangefinder_sample_capture_ctrl #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM shadow and write counter, sampled mid-cycle.
  initial wr_cnt = 0;
  always @(negedge clk) begin
    if (bus.ram_write && bus.ram_chipselect) begin
      mem[bus.ram_address] <= bus.ram_writedata;
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic t);
    bus.sample_valid = 1'b1;
    bus.sample_data  = d;
    bus.trig_in      = t;
    cycle();
    bus.sample_valid = 1'b0;
    bus.trig_in      = 1'b0;
  endtask

  task automatic arm_pulse(input logic [7:0] pc);
    bus.post_count = pc;
    bus.arm        = 1'b1;
    cycle();
    bus.arm        = 1'b0;
  endtask

  task automatic abort_pulse();
    bus.abort = 1'b1;
    cycle();
    bus.abort = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset_n          = 1'b0;
    bus.arm          = 1'b0;
    bus.abort        = 1'b0;
    bus.post_count   = 8'd0;
    bus.irq_ack      = 1'b0;
    bus.sample_valid = 1'b0;
    bus.sample_data  = 8'd0;
    bus.trig_in      = 1'b0;
    repeat (3) cycle();
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_irq", bus.irq, 0);
    check("rst_write", bus.ram_write, 0);
    check("rst_cs", bus.ram_chipselect, 0);
    check("rst_trig", bus.trig_addr, 0);
    check("rst_start", bus.start_addr, 0);
    reset_n = 1'b1;
    cycle();

    // 1: post 16, trigger at sample 280 -> addr 24, start 41, done after sample 296, 297 writes.
    base = wr_cnt;
    arm_pulse(8'd16);
    check("t1_busy", bus.busy, 1);
    for (int i = 0; i < 300; i++) begin
      send(8'(i), i == 280);
      if (i == 0) begin
        check("t1_lat_write", bus.ram_write, 1);
        check("t1_lat_cs", bus.ram_chipselect, 1);
        check("t1_lat_addr", bus.ram_address, 0);
      end
      if (i == 295) check("t1_done_early", bus.done, 0);
      if (i == 296) begin
        check("t1_done", bus.done, 1);
        check("t1_irq", bus.irq, 1);
        check("t1_busy_off", bus.busy, 0);
      end
    end
    cycle();
    check("t1_writes", wr_cnt - base, 297);
    check("t1_trig", bus.trig_addr, 24);
    check("t1_start", bus.start_addr, 41);
    check("t1_mem_trig", mem[24], 24);
    check("t1_mem_last", mem[40], 40);
    check("t1_mem_oldest", mem[41], 41);

    // 2: trig_in held high from the first sample; FILL ignores it, first trigger is sample 239.
    arm_pulse(8'd16);
    check("t2_irq_cleared", bus.irq, 0);
    check("t2_busy", bus.busy, 1);
    for (int i = 0; i < 256; i++) send(8'(i), 1'b1);
    check("t2_done", bus.done, 1);
    check("t2_trig", bus.trig_addr, 239);
    check("t2_start", bus.start_addr, 0);
    cycle();
    check("t2_mem_trig", mem[239], 239);

    // 3: abort from DONE clears irq; post 0 -> trigger sample 255 finishes at once.
    abort_pulse();
    check("t3_abort_irq", bus.irq, 0);
    check("t3_abort_done", bus.done, 0);
    arm_pulse(8'd0);
    for (int i = 0; i < 256; i++) begin
      send(8'(i), (i == 254) || (i == 255));
      if (i == 254) check("t3_fill_ignore", bus.done, 0);
    end
    check("t3_done", bus.done, 1);
    check("t3_trig", bus.trig_addr, 255);
    check("t3_start", bus.start_addr, 0);
    cycle();
    check("t3_mem_trig", mem[255], 255);

    // 4: post 255 skips FILL; first sample is the trigger at addr 0, then 255 more writes.
    base = wr_cnt;
    arm_pulse(8'd255);
    check("t4_busy", bus.busy, 1);
    send(8'hA5, 1'b1);
    check("t4_trig", bus.trig_addr, 0);
    check("t4_start", bus.start_addr, 0);
    for (int j = 1; j < 256; j++) begin
      send(8'(j), 1'b0);
      if (j == 254) check("t4_done_early", bus.done, 0);
    end
    check("t4_done", bus.done, 1);
    cycle();
    check("t4_writes", wr_cnt - base, 256);

    // 5: gapped stream, arm while busy ignored, abort mid-POST stops all writes.
    arm_pulse(8'd4);
    for (int i = 0; i < 254; i++) begin
      send(8'(i), i == 251);
      if (i == 0) begin
        bus.post_count = 8'd200;
        bus.arm        = 1'b1;
        cycle();
        bus.arm        = 1'b0;
        bus.post_count = 8'd4;
        cycle();
      end else begin
        cycle();
        cycle();
      end
      if (i == 251) begin
        check("t5_trig", bus.trig_addr, 251);
        check("t5_start", bus.start_addr, 0);
      end
    end
    check("t5_busy_post", bus.busy, 1);
    abort_pulse();
    check("t5_abort_busy", bus.busy, 0);
    check("t5_abort_done", bus.done, 0);
    cycle();
    base = wr_cnt;
    for (int i = 0; i < 10; i++) send(8'(i), 1'b1);
    cycle();
    check("t5_no_write", wr_cnt - base, 0);
    check("t5_trig_held", bus.trig_addr, 251);
    arm_pulse(8'd255);
    check("t5_rearm_busy", bus.busy, 1);
    send(8'h11, 1'b1);
    check("t5_rearm_trig", bus.trig_addr, 0);
    abort_pulse();

    // 6: irq_ack coincident with DONE entry leaves irq set; a lone irq_ack clears it.
    arm_pulse(8'd0);
    for (int i = 0; i < 256; i++) begin
      bus.irq_ack = (i == 255);
      send(8'(i), i == 255);
    end
    bus.irq_ack = 1'b0;
    check("t6_irq_entry_wins", bus.irq, 1);
    check("t6_done", bus.done, 1);
    bus.irq_ack = 1'b1;
    cycle();
    bus.irq_ack = 1'b0;
    check("t6_irq_ack", bus.irq, 0);
    check("t6_done_kept", bus.done, 1);

    // Asynchronous reset while in WAIT with a write in flight.
    arm_pulse(8'd16);
    for (int i = 0; i < 241; i++) send(8'(i), 1'b0);
    check("t6_wait_busy", bus.busy, 1);
    check("t6_wait_write", bus.ram_write, 1);
    #2 reset_n = 1'b0;
    #1;
    check("t6_arst_busy", bus.busy, 0);
    check("t6_arst_write", bus.ram_write, 0);
    check("t6_arst_cs", bus.ram_chipselect, 0);
    check("t6_arst_trig", bus.trig_addr, 0);
    check("t6_arst_addr", bus.ram_address, 0);
    check("t6_arst_done", bus.done, 0);
    cycle();
    reset_n = 1'b1;
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
